// File: rtl/sys_defs.sv
// Shared definitions for the data-cache miss path: MSHR entry states,
// memory bus command encodings and cache address field positions.
package sys_defs;

  typedef enum logic [1:0] {
    MSHR_FREE       = 2'd0,
    MSHR_WAIT_ISSUE = 2'd1,
    MSHR_WAIT_RESP  = 2'd2,
    MSHR_RESP_READY = 2'd3
  } mshr_state_e;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  localparam int DCACHE_IDX_W   = 4;
  localparam int DCACHE_TAG_W   = 9;
  localparam int MEM_TAG_W      = 4;
  localparam int BLK_OFS_W      = 3;
  localparam int BLK_ADDR_W     = 64 - BLK_OFS_W;

  // Byte-address positions of the set index (addr[6:3]) and tag (addr[15:7]).
  localparam int DCACHE_IDX_LSB = 3;
  localparam int DCACHE_TAG_LSB = 7;

  // The same fields expressed relative to a stored block address addr[63:3].
  localparam int BLK_IDX_LSB    = DCACHE_IDX_LSB - BLK_OFS_W;
  localparam int BLK_TAG_LSB    = DCACHE_TAG_LSB - BLK_OFS_W;

endpackage

// File: rtl/dcache_miss_handler_pick.sv
// Lowest-index find-first-set: reports whether any request bit is set and
// the index of the lowest one.
module dcache_mshr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/dcache_miss_handler.sv
// Load-miss controller for the 2-way, 16-set, 64-bit-block data cache.
// Holds up to MSHR_DEPTH outstanding load misses, issues block-aligned
// BUS_LOAD requests, matches tagged responses and drains one fill plus
// load wakeup per cycle.
// Optional feature: define DCACHE_MSHR_MERGE_EN to let a new miss piggyback
// on an in-flight request (WAIT_RESP entry) for the same block.
module dcache_miss_handler
  import sys_defs::*;
#(
  parameter int MSHR_DEPTH = 4,
  parameter int LQ_ID_W    = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    miss_valid,
  input  logic [63:0]             miss_addr,
  input  logic [LQ_ID_W-1:0]      miss_lq_id,
  output logic                    miss_ready,
  input  logic                    mem_grant,
  output logic [1:0]              proc2mem_command,
  output logic [63:0]             proc2mem_addr,
  input  logic [3:0]              mem2proc_response,
  input  logic [63:0]             mem2proc_data,
  input  logic [3:0]              mem2proc_tag,
  output logic                    wr_mem_en,
  output logic [DCACHE_IDX_W-1:0] wr_mem_idx,
  output logic [DCACHE_TAG_W-1:0] wr_mem_tag,
  output logic [63:0]             wr_mem_data,
  output logic                    ld_done_valid,
  output logic [LQ_ID_W-1:0]      ld_done_lq_id,
  output logic [63:0]             ld_done_data
);

  localparam int IDX_W = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;

  mshr_state_e              state_reg [MSHR_DEPTH];
  mshr_state_e              state_next[MSHR_DEPTH];
  logic [BLK_ADDR_W-1:0]    blk_reg   [MSHR_DEPTH];
  logic [BLK_ADDR_W-1:0]    blk_next  [MSHR_DEPTH];
  logic [LQ_ID_W-1:0]       lq_reg    [MSHR_DEPTH];
  logic [LQ_ID_W-1:0]       lq_next   [MSHR_DEPTH];
  logic [MEM_TAG_W-1:0]     tag_reg   [MSHR_DEPTH];
  logic [MEM_TAG_W-1:0]     tag_next  [MSHR_DEPTH];
  logic [63:0]              data_reg  [MSHR_DEPTH];
  logic [63:0]              data_next [MSHR_DEPTH];

  logic [MSHR_DEPTH-1:0]    free_vec;
  logic [MSHR_DEPTH-1:0]    issue_vec;
  logic [MSHR_DEPTH-1:0]    ready_vec;

  logic                     alloc_valid;
  logic [IDX_W-1:0]         alloc_idx;
  logic                     issue_valid;
  logic [IDX_W-1:0]         issue_idx;
  logic                     drain_valid;
  logic [IDX_W-1:0]         drain_idx;

  logic                     accept;
  logic                     issue_fire;
  logic                     issue_ok;
  logic                     resp_hit;
  logic [BLK_ADDR_W-1:0]    miss_blk;
  logic [BLK_ADDR_W-1:0]    drain_blk;

  // Byte offset within the block is irrelevant: requests are block-aligned.
  logic                     unused_offset_bits;
  assign unused_offset_bits = ^miss_addr[BLK_OFS_W-1:0];

  for (genvar gi = 0; gi < MSHR_DEPTH; gi++) begin : g_vec
    assign free_vec[gi]  = (state_reg[gi] == MSHR_FREE);
    assign issue_vec[gi] = (state_reg[gi] == MSHR_WAIT_ISSUE);
    assign ready_vec[gi] = (state_reg[gi] == MSHR_RESP_READY);
  end

  dcache_mshr_pick #(.N(MSHR_DEPTH), .W(IDX_W)) u_pick_alloc (
    .req   (free_vec),
    .valid (alloc_valid),
    .idx   (alloc_idx)
  );

  dcache_mshr_pick #(.N(MSHR_DEPTH), .W(IDX_W)) u_pick_issue (
    .req   (issue_vec),
    .valid (issue_valid),
    .idx   (issue_idx)
  );

  dcache_mshr_pick #(.N(MSHR_DEPTH), .W(IDX_W)) u_pick_drain (
    .req   (ready_vec),
    .valid (drain_valid),
    .idx   (drain_idx)
  );

  assign miss_blk   = miss_addr[63:BLK_OFS_W];
  assign miss_ready = alloc_valid;
  assign accept     = miss_valid && alloc_valid;
  assign issue_fire = issue_valid && mem_grant;
  assign issue_ok   = issue_fire && (mem2proc_response != '0);
  assign resp_hit   = (mem2proc_tag != '0);

`ifdef DCACHE_MSHR_MERGE_EN
  logic [MSHR_DEPTH-1:0]    merge_vec;
  logic                     merge_valid;
  logic [MEM_TAG_W-1:0]     merge_tag;

  for (genvar gi = 0; gi < MSHR_DEPTH; gi++) begin : g_merge
    assign merge_vec[gi] = (state_reg[gi] == MSHR_WAIT_RESP) && (blk_reg[gi] == miss_blk);
  end

  // Tag of the lowest in-flight request for the same block, if any.
  always_comb begin
    merge_valid = 1'b0;
    merge_tag   = '0;
    for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
      if (merge_vec[i]) begin
        merge_valid = 1'b1;
        merge_tag   = tag_reg[i];
      end
    end
  end
`endif

  // Per-entry next state: each entry is in exactly one state, so allocate,
  // issue, response and drain never collide on the same entry.
  always_comb begin
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      state_next[i] = state_reg[i];
      blk_next[i]   = blk_reg[i];
      lq_next[i]    = lq_reg[i];
      tag_next[i]   = tag_reg[i];
      data_next[i]  = data_reg[i];
      case (state_reg[i])
        MSHR_FREE: begin
          if (accept && (alloc_idx == IDX_W'(i))) begin
            blk_next[i]   = miss_blk;
            lq_next[i]    = miss_lq_id;
            state_next[i] = MSHR_WAIT_ISSUE;
`ifdef DCACHE_MSHR_MERGE_EN
            if (merge_valid) begin
              tag_next[i]   = merge_tag;
              state_next[i] = MSHR_WAIT_RESP;
              if (resp_hit && (mem2proc_tag == merge_tag)) begin
                data_next[i]  = mem2proc_data;
                state_next[i] = MSHR_RESP_READY;
              end
            end
`endif
          end
        end
        MSHR_WAIT_ISSUE: begin
          if (issue_ok && (issue_idx == IDX_W'(i))) begin
            tag_next[i]   = mem2proc_response;
            state_next[i] = MSHR_WAIT_RESP;
          end
        end
        MSHR_WAIT_RESP: begin
          if (resp_hit && (tag_reg[i] == mem2proc_tag)) begin
            data_next[i]  = mem2proc_data;
            state_next[i] = MSHR_RESP_READY;
          end
        end
        MSHR_RESP_READY: begin
          if (drain_valid && (drain_idx == IDX_W'(i))) begin
            state_next[i] = MSHR_FREE;
          end
        end
        default: state_next[i] = MSHR_FREE;
      endcase
    end
  end

  // Entry registers; only the state needs reset, payload is gated by state.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (reset) begin
        state_reg[i] <= MSHR_FREE;
      end else begin
        state_reg[i] <= state_next[i];
      end
      blk_reg[i]  <= blk_next[i];
      lq_reg[i]   <= lq_next[i];
      tag_reg[i]  <= tag_next[i];
      data_reg[i] <= data_next[i];
    end
  end

  assign drain_blk = blk_reg[drain_idx];

  // Bus request from the lowest waiting entry, only while granted.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    if (issue_fire) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = {blk_reg[issue_idx], {BLK_OFS_W{1'b0}}};
    end
  end

  // Fill and wakeup from the lowest ready entry; zero when not strobed.
  always_comb begin
    wr_mem_en     = drain_valid;
    ld_done_valid = drain_valid;
    wr_mem_idx    = '0;
    wr_mem_tag    = '0;
    wr_mem_data   = '0;
    ld_done_lq_id = '0;
    ld_done_data  = '0;
    if (drain_valid) begin
      wr_mem_idx    = drain_blk[BLK_IDX_LSB +: DCACHE_IDX_W];
      wr_mem_tag    = drain_blk[BLK_TAG_LSB +: DCACHE_TAG_W];
      wr_mem_data   = data_reg[drain_idx];
      ld_done_lq_id = lq_reg[drain_idx];
      ld_done_data  = data_reg[drain_idx];
    end
  end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Self-checking bench for dcache_miss_handler: directed scenarios with
// fixed expectations, then randomized traffic against a transaction model.
module tb_dcache_miss_handler;
  import sys_defs::*;

  localparam int DEPTH = 4;
  localparam int LQW   = 3;
  localparam int S_FREE = 0, S_ISSUE = 1, S_WAIT = 2, S_READY = 3;

  logic            clock, reset;
  logic            miss_valid;
  logic [63:0]     miss_addr;
  logic [LQW-1:0]  miss_lq_id;
  logic            miss_ready;
  logic            mem_grant;
  logic [1:0]      proc2mem_command;
  logic [63:0]     proc2mem_addr;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic            wr_mem_en;
  logic [3:0]      wr_mem_idx;
  logic [8:0]      wr_mem_tag;
  logic [63:0]     wr_mem_data;
  logic            ld_done_valid;
  logic [LQW-1:0]  ld_done_lq_id;
  logic [63:0]     ld_done_data;

  int checks = 0;
  int errors = 0;

  // Model: one slot per miss entry, holding the byte-aligned block address.
  int              m_st  [DEPTH];
  logic [63:0]     m_addr[DEPTH];
  logic [LQW-1:0]  m_lq  [DEPTH];
  logic [3:0]      m_tag [DEPTH];
  logic [63:0]     m_data[DEPTH];

  logic            e_ready, e_fill;
  logic [1:0]      e_cmd;
  logic [63:0]     e_addr, e_data;
  logic [3:0]      e_idx;
  logic [8:0]      e_tag;
  logic [LQW-1:0]  e_lq;

  dcache_miss_handler #(.MSHR_DEPTH(DEPTH), .LQ_ID_W(LQW)) dut (
    .clock             (clock),
    .reset             (reset),
    .miss_valid        (miss_valid),
    .miss_addr         (miss_addr),
    .miss_lq_id        (miss_lq_id),
    .miss_ready        (miss_ready),
    .mem_grant         (mem_grant),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .wr_mem_en         (wr_mem_en),
    .wr_mem_idx        (wr_mem_idx),
    .wr_mem_tag        (wr_mem_tag),
    .wr_mem_data       (wr_mem_data),
    .ld_done_valid     (ld_done_valid),
    .ld_done_lq_id     (ld_done_lq_id),
    .ld_done_data      (ld_done_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int first_in(input int st[DEPTH], input int s);
    for (int i = 0; i < DEPTH; i++) if (st[i] == s) return i;
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_update();
    int o_st[DEPTH];
    logic [3:0] o_tag[DEPTH];
    int dr, is, fr;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_st[i] = S_FREE;
      return;
    end
    o_st = m_st;
    o_tag = m_tag;
    dr = first_in(o_st, S_READY);
    is = first_in(o_st, S_ISSUE);
    fr = first_in(o_st, S_FREE);
    if (dr >= 0) m_st[dr] = S_FREE;
    if (is >= 0 && mem_grant && mem2proc_response != 4'd0) begin
      m_st[is] = S_WAIT;
      m_tag[is] = mem2proc_response;
    end
    if (mem2proc_tag != 4'd0)
      for (int i = 0; i < DEPTH; i++)
        if (o_st[i] == S_WAIT && o_tag[i] == mem2proc_tag) begin
          m_st[i] = S_READY;
          m_data[i] = mem2proc_data;
        end
    if (miss_valid && fr >= 0) begin
`ifdef DCACHE_MSHR_MERGE_EN
      int mg;
      mg = -1;
      for (int i = DEPTH - 1; i >= 0; i--)
        if (o_st[i] == S_WAIT && m_addr[i][63:3] == miss_addr[63:3]) mg = i;
`endif
      m_addr[fr] = {miss_addr[63:3], 3'b000};
      m_lq[fr] = miss_lq_id;
      m_st[fr] = S_ISSUE;
`ifdef DCACHE_MSHR_MERGE_EN
      if (mg >= 0) begin
        m_tag[fr] = o_tag[mg];
        m_st[fr] = S_WAIT;
        if (mem2proc_tag == o_tag[mg]) begin
          m_st[fr] = S_READY;
          m_data[fr] = mem2proc_data;
        end
      end
`endif
    end
  endtask

  // Expected outputs for the current cycle from model contents and grant.
  task automatic model_outputs();
    int is, dr;
    logic [63:0] a;
    is = first_in(m_st, S_ISSUE);
    dr = first_in(m_st, S_READY);
    e_ready = (first_in(m_st, S_FREE) >= 0);
    e_cmd = BUS_NONE;
    e_addr = 64'd0;
    if (is >= 0 && mem_grant) begin
      e_cmd = BUS_LOAD;
      e_addr = m_addr[is];
    end
    e_fill = 1'b0; e_idx = '0; e_tag = '0; e_data = '0; e_lq = '0;
    if (dr >= 0) begin
      a = m_addr[dr];
      e_fill = 1'b1;
      e_idx = a[6:3];
      e_tag = a[15:7];
      e_data = m_data[dr];
      e_lq = m_lq[dr];
    end
  endtask

  task automatic drive(input logic mv, input logic [63:0] ma, input logic [LQW-1:0] lq,
                       input logic g, input logic [3:0] resp, input logic [3:0] rtag,
                       input logic [63:0] rdata);
    miss_valid = mv; miss_addr = ma; miss_lq_id = lq;
    mem_grant = g; mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdata;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, '0, 1'b0, 4'd0, 4'd0, 64'd0);
  endtask

  task automatic tick();
    model_update();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    checks++;
    if ({miss_ready, proc2mem_command, proc2mem_addr, wr_mem_en, ld_done_valid} !== {1'b1, BUS_NONE, 64'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b cmd=%0d addr=%h fill=%b ld=%b, want 1 0 0 0 0",
               miss_ready, proc2mem_command, proc2mem_addr, wr_mem_en, ld_done_valid);
    end
    checks++;
    if ({wr_mem_idx, wr_mem_tag, wr_mem_data, ld_done_lq_id, ld_done_data} !== '0) begin
      errors++;
      $display("FAIL reset_data_zero: got idx=%h tag=%h data=%h lq=%0d ld=%h, want all 0",
               wr_mem_idx, wr_mem_tag, wr_mem_data, ld_done_lq_id, ld_done_data);
    end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_miss();
    drive(1'b1, 64'h1238, 3'd5, 1'b1, 4'd0, 4'd0, 64'd0);
    checks++;
    if ({miss_ready, proc2mem_command} !== {1'b1, BUS_NONE}) begin
      errors++;
      $display("FAIL single_accept: got ready=%b cmd=%0d, want 1 %0d", miss_ready, proc2mem_command, BUS_NONE);
    end
    tick();
    drive(1'b0, 64'd0, '0, 1'b1, 4'd3, 4'd0, 64'd0);
    checks++;
    if ({proc2mem_command, proc2mem_addr} !== {BUS_LOAD, 64'h1238}) begin
      errors++;
      $display("FAIL single_issue: got cmd=%0d addr=%h, want %0d 1238", proc2mem_command, proc2mem_addr, BUS_LOAD);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 64'd0, '0, 1'b1, 4'd0, 4'd0, 64'd0);
      checks++;
      if ({proc2mem_command, wr_mem_en} !== {BUS_NONE, 1'b0}) begin
        errors++;
        $display("FAIL single_wait%0d: got cmd=%0d fill=%b, want %0d 0", k, proc2mem_command, wr_mem_en, BUS_NONE);
      end
      tick();
    end
    drive(1'b0, 64'd0, '0, 1'b0, 4'd0, 4'd3, 64'hDEADBEEF);
    checks++;
    if (wr_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL single_resp_cycle: got fill=%b, want 0", wr_mem_en);
    end
    tick();
    idle();
    checks++;
    if ({wr_mem_en, wr_mem_idx, wr_mem_tag, wr_mem_data} !== {1'b1, 4'd7, 9'h024, 64'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_fill: got en=%b idx=%h tag=%h data=%h, want 1 7 024 deadbeef",
               wr_mem_en, wr_mem_idx, wr_mem_tag, wr_mem_data);
    end
    checks++;
    if ({ld_done_valid, ld_done_lq_id, ld_done_data} !== {1'b1, 3'd5, 64'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_wakeup: got v=%b lq=%0d data=%h, want 1 5 deadbeef",
               ld_done_valid, ld_done_lq_id, ld_done_data);
    end
    tick();
    idle();
    checks++;
    if ({wr_mem_en, ld_done_valid, miss_ready, wr_mem_data} !== {1'b0, 1'b0, 1'b1, 64'd0}) begin
      errors++;
      $display("FAIL single_after: got en=%b ld=%b ready=%b data=%h, want 0 0 1 0",
               wr_mem_en, ld_done_valid, miss_ready, wr_mem_data);
    end
    tick();
    $display("test_single_miss done");
  endtask

  task automatic test_retry();
    drive(1'b1, 64'h2A5, 3'd2, 1'b0, 4'd0, 4'd0, 64'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 64'd0, '0, 1'b1, (k == 3) ? 4'd2 : 4'd0, 4'd0, 64'd0);
      checks++;
      if ({proc2mem_command, proc2mem_addr} !== {BUS_LOAD, 64'h2A0}) begin
        errors++;
        $display("FAIL retry_hold%0d: got cmd=%0d addr=%h, want %0d 2a0", k, proc2mem_command, proc2mem_addr, BUS_LOAD);
      end
      tick();
    end
    drive(1'b0, 64'd0, '0, 1'b1, 4'd0, 4'd0, 64'd0);
    checks++;
    if (proc2mem_command !== BUS_NONE) begin
      errors++;
      $display("FAIL retry_done: got cmd=%0d, want %0d", proc2mem_command, BUS_NONE);
    end
    tick();
    drive(1'b0, 64'd0, '0, 1'b0, 4'd0, 4'd2, 64'h0123_4567_89AB_CDEF);
    tick();
    idle();
    checks++;
    if ({wr_mem_en, wr_mem_idx, wr_mem_tag, ld_done_lq_id, ld_done_data} !== {1'b1, 4'h4, 9'h005, 3'd2, 64'h0123_4567_89AB_CDEF}) begin
      errors++;
      $display("FAIL retry_fill: got en=%b idx=%h tag=%h lq=%0d data=%h, want 1 4 005 2 0123456789abcdef",
               wr_mem_en, wr_mem_idx, wr_mem_tag, ld_done_lq_id, ld_done_data);
    end
    tick();
    $display("test_retry done");
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 64'h8000 + 64'(k) * 64'h100 + 64'(k), LQW'(k + 4), 1'b0, 4'd0, 4'd0, 64'd0);
      checks++;
      if (miss_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_fill%0d: got ready=%b, want 1", k, miss_ready);
      end
      tick();
    end
    drive(1'b1, 64'h9990, 3'd0, 1'b0, 4'd0, 4'd0, 64'd0);
    checks++;
    if (miss_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got ready=%b, want 0", miss_ready);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 64'd0, '0, 1'b1, (k < 4) ? 4'(k + 1) : 4'd0, 4'd0, 64'd0);
      checks++;
      if (k < 4 && {proc2mem_command, proc2mem_addr} !== {BUS_LOAD, 64'h8000 + 64'(k) * 64'h100}) begin
        errors++;
        $display("FAIL full_issue%0d: got cmd=%0d addr=%h, want %0d %h", k, proc2mem_command, proc2mem_addr,
                 BUS_LOAD, 64'h8000 + 64'(k) * 64'h100);
      end else if (k == 4 && proc2mem_command !== BUS_NONE) begin
        errors++;
        $display("FAIL full_no_fifth: got cmd=%0d addr=%h, want %0d", proc2mem_command, proc2mem_addr, BUS_NONE);
      end
      tick();
    end
    for (int s = 0; s < 5; s++) begin
      drive(1'b0, 64'd0, '0, 1'b0, 4'd0, (s < 4) ? 4'(s + 1) : 4'd0, 64'hF00D_0000 + 64'(s));
      checks++;
      if (miss_ready !== ((s >= 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL full_ready_step%0d: got ready=%b, want %b", s, miss_ready, (s >= 2));
      end
      if (s >= 1) begin
        checks++;
        if ({ld_done_valid, ld_done_lq_id, ld_done_data} !== {1'b1, LQW'(s + 3), 64'hF00D_0000 + 64'(s - 1)}) begin
          errors++;
          $display("FAIL full_drain%0d: got v=%b lq=%0d data=%h, want 1 %0d %h", s, ld_done_valid,
                   ld_done_lq_id, ld_done_data, s + 3, 64'hF00D_0000 + 64'(s - 1));
        end
      end
      tick();
    end
    $display("test_full done");
  endtask

  task automatic test_out_of_order();
    int ro[3];
    ro = '{3, 1, 2};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'hA000 + 64'(k) * 64'h8, LQW'(k + 1), 1'b0, 4'd0, 4'd0, 64'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 64'd0, '0, 1'b1, 4'(k + 1), 4'd0, 64'd0);
      tick();
    end
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 64'd0, '0, 1'b0, 4'd0, (s < 3) ? 4'(ro[s]) : 4'd0,
            (s < 3) ? 64'h5550 + 64'(ro[s]) : 64'd0);
      if (s >= 1) begin
        checks++;
        if ({ld_done_valid, ld_done_lq_id, wr_mem_data, wr_mem_idx} !==
            {1'b1, LQW'(ro[s - 1]), 64'h5550 + 64'(ro[s - 1]), 4'(ro[s - 1] - 1)}) begin
          errors++;
          $display("FAIL ooo_wake%0d: got v=%b lq=%0d data=%h idx=%h, want 1 %0d %h %h", s, ld_done_valid,
                   ld_done_lq_id, wr_mem_data, wr_mem_idx, ro[s - 1], 64'h5550 + 64'(ro[s - 1]), ro[s - 1] - 1);
        end
      end
      tick();
    end
    $display("test_out_of_order done");
  endtask

  task automatic test_merge();
    drive(1'b1, 64'h40, 3'd1, 1'b0, 4'd0, 4'd0, 64'd0);
    tick();
    drive(1'b0, 64'd0, '0, 1'b1, 4'd4, 4'd0, 64'd0);
    tick();
    drive(1'b1, 64'h44, 3'd2, 1'b0, 4'd0, 4'd0, 64'd0);
    tick();
`ifdef DCACHE_MSHR_MERGE_EN
    drive(1'b0, 64'd0, '0, 1'b1, 4'd0, 4'd0, 64'd0);
    checks++;
    if (proc2mem_command !== BUS_NONE) begin
      errors++;
      $display("FAIL merge_no_issue: got cmd=%0d addr=%h, want %0d", proc2mem_command, proc2mem_addr, BUS_NONE);
    end
`else
    drive(1'b0, 64'd0, '0, 1'b1, 4'd5, 4'd0, 64'd0);
    checks++;
    if ({proc2mem_command, proc2mem_addr} !== {BUS_LOAD, 64'h40}) begin
      errors++;
      $display("FAIL merge_off_issue: got cmd=%0d addr=%h, want %0d 40", proc2mem_command, proc2mem_addr, BUS_LOAD);
    end
`endif
    tick();
    drive(1'b0, 64'd0, '0, 1'b0, 4'd0, 4'd4, 64'hCAFE_0040);
    tick();
    idle();
    checks++;
    if ({wr_mem_en, ld_done_lq_id, ld_done_data} !== {1'b1, 3'd1, 64'hCAFE_0040}) begin
      errors++;
      $display("FAIL merge_first: got en=%b lq=%0d data=%h, want 1 1 cafe0040", wr_mem_en, ld_done_lq_id, ld_done_data);
    end
    tick();
`ifdef DCACHE_MSHR_MERGE_EN
    idle();
    checks++;
    if ({wr_mem_en, ld_done_lq_id, ld_done_data} !== {1'b1, 3'd2, 64'hCAFE_0040}) begin
      errors++;
      $display("FAIL merge_second: got en=%b lq=%0d data=%h, want 1 2 cafe0040", wr_mem_en, ld_done_lq_id, ld_done_data);
    end
    tick();
`else
    drive(1'b0, 64'd0, '0, 1'b0, 4'd0, 4'd5, 64'hCAFE_0044);
    checks++;
    if (wr_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL merge_off_gap: got en=%b, want 0", wr_mem_en);
    end
    tick();
    idle();
    checks++;
    if ({wr_mem_en, ld_done_lq_id, ld_done_data} !== {1'b1, 3'd2, 64'hCAFE_0044}) begin
      errors++;
      $display("FAIL merge_off_second: got en=%b lq=%0d data=%h, want 1 2 cafe0044", wr_mem_en, ld_done_lq_id, ld_done_data);
    end
    tick();
`endif
    $display("test_merge done");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 64'h300, 3'd1, 1'b0, 4'd0, 4'd0, 64'd0);
    tick();
    drive(1'b1, 64'h308, 3'd2, 1'b1, 4'd6, 4'd0, 64'd0);
    tick();
    drive(1'b0, 64'd0, '0, 1'b1, 4'd7, 4'd0, 64'd0);
    tick();
    do_reset();
    drive(1'b0, 64'd0, '0, 1'b0, 4'd0, 4'd6, 64'hBAD0_0006);
    checks++;
    if (miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got ready=%b, want 1", miss_ready);
    end
    tick();
    drive(1'b0, 64'd0, '0, 1'b0, 4'd0, 4'd7, 64'hBAD0_0007);
    checks++;
    if ({wr_mem_en, ld_done_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_no_fill: got en=%b ld=%b, want 0 0", wr_mem_en, ld_done_valid);
    end
    tick();
    idle();
    checks++;
    if ({wr_mem_en, ld_done_valid, miss_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_after: got en=%b ld=%b ready=%b, want 0 0 1", wr_mem_en, ld_done_valid, miss_ready);
    end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [63:0] pool[6];
    logic [3:0] outq[$];
    logic [3:0] freeq[$];
    logic [3:0] rt, rs, cand;
    logic mv, g;
    logic [63:0] ma;
    int fails_before;
    pool = '{64'h1000, 64'h1008, 64'h1010, 64'h2040, 64'hFFFF_0000_0000_1230, 64'h0000_7777_0000_0018};
    do_reset();
    fails_before = errors;
    for (int c = 0; c < 400; c++) begin
      outq = {};
      for (int i = 0; i < DEPTH; i++) if (m_st[i] == S_WAIT) outq.push_back(m_tag[i]);
      freeq = {};
      for (int t = 1; t < 16; t++) begin
        bit used;
        used = 1'b0;
        foreach (outq[j]) if (outq[j] == 4'(t)) used = 1'b1;
        if (!used) freeq.push_back(4'(t));
      end
      rt = 4'd0;
      if (outq.size() > 0 && $urandom_range(0, 9) < 4) rt = outq[$urandom_range(0, outq.size() - 1)];
      else if ($urandom_range(0, 19) == 0) rt = freeq[$urandom_range(0, freeq.size() - 1)];
      mv = 1'($urandom_range(0, 1));
      ma = pool[$urandom_range(0, 5)] + 64'($urandom_range(0, 7));
      g = ($urandom_range(0, 9) < 7);
      rs = 4'd0;
      if (g && first_in(m_st, S_ISSUE) >= 0 && $urandom_range(0, 9) < 6) begin
        int p;
        p = $urandom_range(0, freeq.size() - 1);
        cand = freeq[p];
        if (cand == rt) cand = freeq[(p + 1) % freeq.size()];
        rs = cand;
      end
      drive(mv, ma, LQW'($urandom_range(0, 7)), g, rs, rt, {$urandom, $urandom});
      model_outputs();
      checks++;
      if (miss_ready !== e_ready) begin
        errors++;
        $display("FAIL rnd_ready c%0d: got %b want %b", c, miss_ready, e_ready);
      end
      checks++;
      if ({proc2mem_command, proc2mem_addr} !== {e_cmd, e_addr}) begin
        errors++;
        $display("FAIL rnd_bus c%0d: got cmd=%0d addr=%h want cmd=%0d addr=%h", c, proc2mem_command, proc2mem_addr, e_cmd, e_addr);
      end
      checks++;
      if ({wr_mem_en, wr_mem_idx, wr_mem_tag, wr_mem_data} !== {e_fill, e_idx, e_tag, e_data}) begin
        errors++;
        $display("FAIL rnd_fill c%0d: got en=%b idx=%h tag=%h data=%h want en=%b idx=%h tag=%h data=%h", c,
                 wr_mem_en, wr_mem_idx, wr_mem_tag, wr_mem_data, e_fill, e_idx, e_tag, e_data);
      end
      checks++;
      if ({ld_done_valid, ld_done_lq_id, ld_done_data} !== {e_fill, e_lq, e_data}) begin
        errors++;
        $display("FAIL rnd_wake c%0d: got v=%b lq=%0d data=%h want v=%b lq=%0d data=%h", c,
                 ld_done_valid, ld_done_lq_id, ld_done_data, e_fill, e_lq, e_data);
      end
      tick();
    end
    $display("test_random done: %0d new errors", errors - fails_before);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_st[i] = S_FREE; m_addr[i] = '0; m_lq[i] = '0; m_tag[i] = '0; m_data[i] = '0;
    end
    reset = 1'b1;
    miss_valid = 1'b0; miss_addr = '0; miss_lq_id = '0; mem_grant = 1'b0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
    @(negedge clock);
    test_reset();
    test_single_miss();
    test_retry();
    test_full();
    test_out_of_order();
    test_merge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
